// File: rtl/turn_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : turn_fsm_pkg
// Description : Shared types and constants for the Chicken Cha-Cha-Cha
//               game-flow controller and the downstream turn counter.
//               - state_t       : FSM state encoding (also exported on a port)
//               - PCNT_W        : player-count width, shared with turn counter
//               - MIN/MAX_PLAYERS and players_legal() range check
// Revision    : 1.0 - initial release
// ============================================================================
package turn_fsm_pkg;

  localparam int PCNT_W      = 3;
  localparam int MIN_PLAYERS = 2;
  localparam int MAX_PLAYERS = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_FLIP = 3'd1,
    ST_REVEAL    = 3'd2,
    ST_JUDGE     = 3'd3,
    ST_MOVE      = 3'd4,
    ST_CHECK     = 3'd5,
    ST_NEXT      = 3'd6,
    ST_DONE      = 3'd7
  } state_t;

  function automatic logic players_legal(input logic [PCNT_W-1:0] n);
    return (n >= PCNT_W'(MIN_PLAYERS)) && (n <= PCNT_W'(MAX_PLAYERS));
  endfunction

endpackage
`default_nettype wire

// File: rtl/turn_fsm_reveal_timer.sv
`default_nettype none
// ============================================================================
// Module      : turn_fsm_reveal_timer
// Description : Loadable down-counter with a zero flag; times how long the
//               flipped card stays revealed. Saturates at zero.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               load_i        - load load_val_i (has priority over dec_i)
//               load_val_i    - value to load
//               dec_i         - decrement by one when non-zero
//               zero_o        - count currently equals zero
// Revision    : 1.0 - initial release
// ============================================================================
module turn_fsm_reveal_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  // Decoded from the count flop; only consumed inside the FSM, never
  // driven straight to a module output.
  assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/turn_fsm.sv
`default_nettype none
// ============================================================================
// Module      : turn_fsm
// Description : Game-flow controller for Chicken Cha-Cha-Cha. Sequences each
//               turn (wait flip -> reveal -> judge -> move/next) and detects
//               game end. Drives the turn counter's strobes.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               start        - start/restart pulse (IDLE and DONE only)
//               n_players    - requested player count (2..4 legal)
//               flip         - card flipped pulse (WAIT_FLIP only)
//               card_match   - sampled in JUDGE
//               win          - sampled in CHECK
//               n_latched    - player count frozen at game start
//               state        - current state encoding
//               card_show    - card revealed
//               move_en      - one-cycle advance-chicken strobe
//               next_turn    - one-cycle strobe to the turn counter
//               new_game     - one-cycle strobe resetting counter and board
//               game_done    - high while in DONE
// Revision    : 1.0 - initial release
// ============================================================================
module turn_fsm
  import turn_fsm_pkg::*;
#(
  parameter int unsigned REVEAL_CYCLES = 50000000,
  parameter int          CNT_W         = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PCNT_W-1:0] n_players,
  input  logic              flip,
  input  logic              card_match,
  input  logic              win,
  output logic [PCNT_W-1:0] n_latched,
  output logic [2:0]        state,
  output logic              card_show,
  output logic              move_en,
  output logic              next_turn,
  output logic              new_game,
  output logic              game_done
);

  // Loading N-1 and leaving REVEAL on the cycle the counter reads zero
  // gives exactly N cycles of card_show.
  localparam logic [CNT_W-1:0] REVEAL_LOAD = CNT_W'(REVEAL_CYCLES - 1);

  state_t            state_q;
  logic [PCNT_W-1:0] n_latched_q;
  logic              card_show_q;
  logic              move_en_q;
  logic              next_turn_q;
  logic              new_game_q;
  logic              game_done_q;

  logic timer_load;
  logic timer_dec;
  logic timer_zero;

  assign timer_load = (state_q == ST_WAIT_FLIP) && flip;
  assign timer_dec  = (state_q == ST_REVEAL);

  turn_fsm_reveal_timer #(
    .CNT_W (CNT_W)
  ) u_reveal_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load),
    .load_val_i (REVEAL_LOAD),
    .dec_i      (timer_dec),
    .zero_o     (timer_zero)
  );

  // Every output is a flop: the turn counter edge-detects next_turn, so
  // no combinational decode may reach the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      n_latched_q <= '0;
      card_show_q <= 1'b0;
      move_en_q   <= 1'b0;
      next_turn_q <= 1'b0;
      new_game_q  <= 1'b0;
      game_done_q <= 1'b0;
    end else begin
      // Strobes are single-cycle; each is re-asserted only on entry to
      // its own state, which also keeps them mutually exclusive.
      move_en_q   <= 1'b0;
      next_turn_q <= 1'b0;
      new_game_q  <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (start && players_legal(n_players)) begin
            n_latched_q <= n_players;
            new_game_q  <= 1'b1;
            state_q     <= ST_WAIT_FLIP;
          end
        end
        ST_WAIT_FLIP: begin
          // flip wins over a simultaneous start; start is ignored here.
          if (flip) begin
            card_show_q <= 1'b1;
            state_q     <= ST_REVEAL;
          end
        end
        ST_REVEAL: begin
          if (timer_zero) begin
            card_show_q <= 1'b0;
            state_q     <= ST_JUDGE;
          end
        end
        ST_JUDGE: begin
          if (card_match) begin
            move_en_q <= 1'b1;
            state_q   <= ST_MOVE;
          end else begin
            next_turn_q <= 1'b1;
            state_q     <= ST_NEXT;
          end
        end
        ST_MOVE: begin
          state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          if (win) begin
            game_done_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            state_q <= ST_WAIT_FLIP;
          end
        end
        ST_NEXT: begin
          state_q <= ST_WAIT_FLIP;
        end
        ST_DONE: begin
          if (start) begin
            game_done_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign state     = state_q;
  assign n_latched = n_latched_q;
  assign card_show = card_show_q;
  assign move_en   = move_en_q;
  assign next_turn = next_turn_q;
  assign new_game  = new_game_q;
  assign game_done = game_done_q;

endmodule
`default_nettype wire

// File: tb/tb_turn_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_turn_fsm
// Description : Self-checking bench for turn_fsm (REVEAL_CYCLES=4). A
//               timeline model predicts each turn as a sequence of output
//               vectors; directed scenarios pin literal values, then a
//               randomized run is compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_turn_fsm;

  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rst, start, flip, card_match, win;
  logic [2:0] n_players;
  logic [2:0] n_latched, state;
  logic       card_show, move_en, next_turn, new_game, game_done;

  int n_pass  = 0;
  int n_total = 0;

  turn_fsm #(
    .REVEAL_CYCLES (R),
    .CNT_W         (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .n_players  (n_players),
    .flip       (flip),
    .card_match (card_match),
    .win        (win),
    .n_latched  (n_latched),
    .state      (state),
    .card_show  (card_show),
    .move_en    (move_en),
    .next_turn  (next_turn),
    .new_game   (new_game),
    .game_done  (game_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- timeline model ----------------
  typedef struct packed {
    logic [2:0] st;
    logic show, mv, nx, ng, dn;
  } vec_t;

  vec_t q[$];
  vec_t exp_v;
  int   mode = 0;            // resting phase: 0 idle, 1 waiting for flip, 7 done
  logic [2:0] mnlat = '0;
  bit   model_valid = 0;

  function automatic vec_t mk(input int st, input bit show, input bit mv,
                              input bit nx, input bit ng, input bit dn);
    vec_t v;
    v.st = 3'(st); v.show = show; v.mv = mv; v.nx = nx; v.ng = ng; v.dn = dn;
    return v;
  endfunction

  function automatic vec_t rest(input int m);
    return mk(m, 0, 0, 0, 0, m == 7);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      mode = 0; mnlat = '0; exp_v = rest(0); model_valid = 1;
    end else if (model_valid) begin
      if (q.size() > 0) begin
        exp_v = q.pop_front();
      end else begin
        case (mode)
          0: begin
            if (start && n_players >= 3'd2 && n_players <= 3'd4) begin
              mnlat = n_players; exp_v = mk(1, 0, 0, 0, 1, 0); mode = 1;
            end else exp_v = rest(0);
          end
          1: begin
            if (flip) begin
              // A whole turn is known at flip: the bench holds card_match/win.
              exp_v = mk(2, 1, 0, 0, 0, 0);
              for (int i = 1; i < R; i++) q.push_back(mk(2, 1, 0, 0, 0, 0));
              q.push_back(mk(3, 0, 0, 0, 0, 0));
              if (card_match) begin
                q.push_back(mk(4, 0, 1, 0, 0, 0));
                q.push_back(mk(5, 0, 0, 0, 0, 0));
                mode = win ? 7 : 1;
              end else begin
                q.push_back(mk(6, 0, 0, 1, 0, 0));
                mode = 1;
              end
              q.push_back(rest(mode));
            end else exp_v = rest(1);
          end
          default: begin
            if (start) begin mode = 0; exp_v = rest(0); end
            else exp_v = rest(7);
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("m_state",     int'(state),     int'(exp_v.st));
      chk("m_card_show", int'(card_show), int'(exp_v.show));
      chk("m_move_en",   int'(move_en),   int'(exp_v.mv));
      chk("m_next_turn", int'(next_turn), int'(exp_v.nx));
      chk("m_new_game",  int'(new_game),  int'(exp_v.ng));
      chk("m_game_done", int'(game_done), int'(exp_v.dn));
      chk("m_n_latched", int'(n_latched), int'(mnlat));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  // Called with card_show already high; returns remaining high cycles.
  task automatic count_reveal(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (card_show !== 1'b1) break;
      n++;
      step();
    end
  endtask

  int n1, n2;

  initial begin
    rst = 1; start = 0; flip = 0; card_match = 0; win = 0; n_players = 3'd0;
    repeat (3) step();
    chk("rst_state", int'(state), 0);
    chk("rst_n_latched", int'(n_latched), 0);
    chk("rst_outs", int'({card_show, move_en, next_turn, new_game, game_done}), 0);
    rst = 0;

    // Illegal player count ignored
    step(); start = 1; n_players = 3'd5;
    step(); start = 0;
    chk("bad_n_state", int'(state), 0);
    chk("bad_n_new_game", int'(new_game), 0);

    // Legal start with 3 players; later n_players change has no effect
    start = 1; n_players = 3'd3;
    step(); start = 0; n_players = 3'd4;
    chk("start_new_game", int'(new_game), 1);
    chk("start_n_latched", int'(n_latched), 3);
    chk("start_state", int'(state), 1);
    step();
    chk("new_game_1cyc", int'(new_game), 0);
    chk("n_latched_hold", int'(n_latched), 3);

    // No match -> next_turn
    card_match = 0; flip = 1;
    step(); flip = 0;
    count_reveal(n1);
    chk("nomatch_reveal_len", n1, R);
    chk("nomatch_judge", int'(state), 3);
    step();
    chk("nomatch_next_state", int'(state), 6);
    chk("nomatch_next_turn", int'(next_turn), 1);
    chk("nomatch_move_en", int'(move_en), 0);
    step();
    chk("nomatch_back_wait", int'(state), 1);
    chk("next_turn_1cyc", int'(next_turn), 0);

    // Match, no win; flip+start during REVEAL are ignored
    card_match = 1; win = 0; flip = 1;
    step(); flip = 0;
    chk("match_reveal_entry", int'(state), 2);
    flip = 1; start = 1;
    step(); flip = 0; start = 0;
    chk("reveal_ignore_flip", int'(state), 2);
    count_reveal(n2);
    chk("match_reveal_len", 1 + n2, R);
    chk("match_judge", int'(state), 3);
    step();
    chk("match_move_en", int'(move_en), 1);
    chk("match_move_state", int'(state), 4);
    step();
    chk("match_check_state", int'(state), 5);
    step();
    chk("match_back_wait", int'(state), 1);
    chk("match_no_next_turn", int'(next_turn), 0);

    // start alone in WAIT_FLIP is ignored
    start = 1;
    step(); start = 0;
    chk("wait_ignore_start", int'(state), 1);
    chk("wait_ignore_start_ng", int'(new_game), 0);

    // start+flip together act as flip; match + win -> DONE
    card_match = 1; win = 1; start = 1; flip = 1;
    step(); start = 0; flip = 0;
    chk("startflip_state", int'(state), 2);
    chk("startflip_new_game", int'(new_game), 0);
    count_reveal(n1);
    chk("win_reveal_len", n1, R);
    step(); step(); step();
    chk("win_state", int'(state), 7);
    chk("win_game_done", int'(game_done), 1);
    step();
    chk("done_hold", int'(game_done), 1);
    start = 1;
    step(); start = 0;
    chk("restart_state", int'(state), 0);
    chk("restart_game_done", int'(game_done), 0);

    // Reset during 2nd REVEAL cycle
    start = 1; n_players = 3'd2;
    step(); start = 0;
    chk("g2_state", int'(state), 1);
    flip = 1;
    step(); flip = 0;
    step();
    chk("rst_mid_pre", int'(state), 2);
    rst = 1;
    step(); rst = 0;
    chk("rst_mid_state", int'(state), 0);
    chk("rst_mid_card_show", int'(card_show), 0);
    chk("rst_mid_n_latched", int'(n_latched), 0);
    chk("rst_mid_strobes", int'({move_en, next_turn, new_game}), 0);

    // Randomized run, checked every cycle against the model
    for (int c = 0; c < 4000; c++) begin
      step();
      rst       = ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 7) == 0);
      n_players = 3'($urandom_range(0, 7));
      flip      = ($urandom_range(0, 2) == 0);
      if (q.size() == 0) begin
        card_match = 1'($urandom_range(0, 1));
        win        = ($urandom_range(0, 3) == 0);
      end
    end
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
